// File: rtl/ext_sram_ctrl.sv
// Pipelined ZBT/NoBL SRAM controller: single-word read/write commands in, registered pad signals out.
// Write data is on the bus WR_LAT+1 cycles after acceptance; read data returns RD_LAT+2 cycles after acceptance.
module ext_sram_ctrl #(
  parameter int AWIDTH = 21,
  parameter int DWIDTH = 36,
  parameter int WR_LAT = 2,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              idle,
  output logic [AWIDTH-1:0] RAM_A,
  output logic              RAM_WEn,
  output logic              RAM_LDn,
  output logic              RAM_OEn,
  output logic              RAM_CENn,
  output logic [DWIDTH-1:0] RAM_D_po,
  input  logic [DWIDTH-1:0] RAM_D_pi,
  output logic              RAM_D_poe
);

  logic              r_rd_acc;
  logic [AWIDTH-1:0] r_ram_a;
  logic              r_ram_wen;
  logic              r_ram_ldn;
  logic              r_ram_oen;
  logic [DWIDTH-1:0] r_ram_d_po;
  logic              r_ram_d_poe;
  logic [WR_LAT-1:0] r_wr_flg;
  logic [DWIDTH-1:0] r_wr_dat [WR_LAT];
  logic [RD_LAT-1:0] r_rd_flg;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;

  logic w_acc;
  logic w_wr_acc;
  logic w_rd_acc;

  // A write right after a read is held off one cycle so the bus can turn around.
  assign req_ready = ~(r_rd_acc & req_we);
  assign w_acc     = req_valid & req_ready;
  assign w_wr_acc  = w_acc & req_we;
  assign w_rd_acc  = w_acc & ~req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_acc    <= 1'b0;
      r_ram_a     <= '0;
      r_ram_wen   <= 1'b1;
      r_ram_ldn   <= 1'b1;
      r_ram_oen   <= 1'b1;
      r_ram_d_po  <= '0;
      r_ram_d_poe <= 1'b1;
      r_wr_flg    <= '0;
      r_rd_flg    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      for (int i = 0; i < WR_LAT; i++) begin
        r_wr_dat[i] <= '0;
      end
    end else begin
      r_rd_acc  <= w_rd_acc;
      r_ram_ldn <= ~w_acc;
      r_ram_wen <= ~w_wr_acc;
      if (w_acc) begin
        r_ram_a <= req_addr;
      end

      for (int i = WR_LAT - 1; i > 0; i--) begin
        r_wr_flg[i] <= r_wr_flg[i-1];
        r_wr_dat[i] <= r_wr_dat[i-1];
      end
      r_wr_flg[0] <= w_wr_acc;
      r_wr_dat[0] <= req_wdata;

      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_rd_flg[i] <= r_rd_flg[i-1];
      end
      r_rd_flg[0] <= w_rd_acc;

      // Final stage lands in the pad registers so drive/OE are IOB-packable.
      r_ram_d_poe <= ~r_wr_flg[WR_LAT-1];
      if (r_wr_flg[WR_LAT-1]) begin
        r_ram_d_po <= r_wr_dat[WR_LAT-1];
      end
      r_ram_oen <= ~r_rd_flg[RD_LAT-1];

      r_rsp_valid <= ~r_ram_oen;
      if (!r_ram_oen) begin
        r_rsp_rdata <= RAM_D_pi;
      end
    end
  end

  assign RAM_A     = r_ram_a;
  assign RAM_WEn   = r_ram_wen;
  assign RAM_LDn   = r_ram_ldn;
  assign RAM_OEn   = r_ram_oen;
  assign RAM_CENn  = 1'b0;
  assign RAM_D_po  = r_ram_d_po;
  assign RAM_D_poe = r_ram_d_poe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign idle      = ~(|r_wr_flg) & ~(|r_rd_flg) & r_ram_ldn;

endmodule
